// File: rtl/fmalza_pipe_pkg.sv
// Shared FMA helpers: the Schmookler-Nowka leading-digit pattern equation and
// the shift-count width rule, also reused by the fused add path.
package fmalza_pipe_pkg;

    // Count width able to hold 0..width+1.
    function automatic int unsigned lza_cw(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    localparam int unsigned LzaCw = lza_cw(3 * 52 + 4);

    // One bit of F from the propagate of the next-higher position and the
    // generate/kill of this and the next-lower position.
    function automatic logic lza_pattern(
        input logic pp1,
        input logic g,
        input logic k,
        input logic gm1,
        input logic km1
    );
        return (pp1 & ((g & ~km1) | (k & ~gm1))) | (~pp1 & ((k & ~km1) | (g & ~gm1)));
    endfunction

endpackage

// File: rtl/fmalza_pipe_lzc_split.sv
// Two-half leading-zero counter with merge; Reg=1 places a register between
// the half counts and the merge (loaded on en_i), Reg=0 is fully combinational.
module lza_lzc_split #(
    parameter int unsigned N   = 161,
    parameter int unsigned CW  = 8,
    parameter bit          Reg = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [N-1:0]  f_i,
    output logic [CW-1:0] cnt_o,
    output logic          zero_o
);
    localparam int LW = int'(N) / 2;
    localparam int UW = int'(N) - LW;

    logic [UW-1:0] hi_f;
    logic [LW-1:0] lo_f;
    logic [CW-1:0] hi_cnt_d, lo_cnt_d, hi_cnt_q, lo_cnt_q, hi_cnt, lo_cnt;
    logic          hi_zero_d, lo_zero_d, hi_zero_q, lo_zero_q, hi_zero, lo_zero;

    assign hi_f = f_i[N-1:LW];
    assign lo_f = f_i[LW-1:0];

    // Scanning upward lets the highest set bit win.
    always_comb begin
        hi_cnt_d = CW'(UW);
        for (int i = 0; i < UW; i++) begin
            if (hi_f[i]) hi_cnt_d = CW'(UW - 1 - i);
        end
        lo_cnt_d = CW'(LW);
        for (int i = 0; i < LW; i++) begin
            if (lo_f[i]) lo_cnt_d = CW'(LW - 1 - i);
        end
    end

    assign hi_zero_d = ~|hi_f;
    assign lo_zero_d = ~|lo_f;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_cnt_q  <= '0;
            lo_cnt_q  <= '0;
            hi_zero_q <= 1'b0;
            lo_zero_q <= 1'b0;
        end else if (en_i) begin
            hi_cnt_q  <= hi_cnt_d;
            lo_cnt_q  <= lo_cnt_d;
            hi_zero_q <= hi_zero_d;
            lo_zero_q <= lo_zero_d;
        end
    end

    assign hi_cnt  = Reg ? hi_cnt_q  : hi_cnt_d;
    assign lo_cnt  = Reg ? lo_cnt_q  : lo_cnt_d;
    assign hi_zero = Reg ? hi_zero_q : hi_zero_d;
    assign lo_zero = Reg ? lo_zero_q : lo_zero_d;

    assign zero_o = hi_zero & lo_zero;
    assign cnt_o  = hi_zero ? CW'(UW) + lo_cnt : hi_cnt;

endmodule

// File: rtl/fmalza_pipe.sv
// Pipelined leading zero anticipator: F pattern, shift count and zero flag with
// valid/ready backpressure, flush and a sideband tag.
module fmalza_pipe
    import fmalza_pipe_pkg::*;
#(
    parameter int unsigned NF     = 52,
    parameter int unsigned WIDTH  = 3 * NF + 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAGW   = 8,
    localparam int unsigned CW    = lza_cw(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  A,
    input  logic [2*NF+1:0]   Pm,
    input  logic              Cin,
    input  logic              sub,
    input  logic [TAGW-1:0]   tag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     SCnt,
    output logic              Zero,
    output logic [TAGW-1:0]   tag_out
);
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("fmalza_pipe: STAGES must be 1, 2 or 3");
    end
    if (WIDTH != 3 * NF + 4) begin : g_bad_width
        $error("fmalza_pipe: WIDTH must equal 3*NF+4");
    end

    logic [WIDTH-1:0] b_op, g_v, k_v, pp1, gm1, km1;
    logic [WIDTH:0]   f_c, lzc_in;

    assign b_op = {{(NF + 1){1'b0}}, Pm, 1'b0};
    assign g_v  = A & b_op;
    assign k_v  = ~A & ~b_op;
    assign pp1  = {sub, A[WIDTH-1:1] ^ b_op[WIDTH-1:1]};
    assign gm1  = {g_v[WIDTH-2:0], Cin};
    assign km1  = {k_v[WIDTH-2:0], ~Cin};

    always_comb begin
        f_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            f_c[i] = lza_pattern(pp1[i], g_v[i], k_v[i], gm1[i], km1[i]);
        end
        f_c[WIDTH] = ~sub & (A[WIDTH-1] ^ b_op[WIDTH-1]);
    end

    // Handshake: ld[k] means stage k may load; ld[STAGES] is the consumer.
    logic [STAGES-1:0] v_q, vin, en;
    logic [STAGES:0]   ld;
    logic [TAGW-1:0]   tag_q   [STAGES];
    logic [TAGW-1:0]   tag_src [STAGES];

    always_comb begin
        ld         = '0;
        ld[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            ld[k] = ~v_q[k] | ld[k+1];
        end
        vin        = '0;
        vin[0]     = in_valid;
        tag_src[0] = tag_in;
        for (int k = 1; k < int'(STAGES); k++) begin
            vin[k]     = v_q[k-1];
            tag_src[k] = tag_q[k-1];
        end
        en = ld[STAGES-1:0] & vin;
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[STAGES-1];
    assign tag_out   = tag_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            v_q <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) v_q[k] <= vin[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(STAGES); k++) tag_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (en[k]) tag_q[k] <= tag_src[k];
            end
        end
    end

    logic mid_en;
    if (STAGES == 1) begin : g_s1
        assign lzc_in = f_c;
        assign mid_en = 1'b0;
    end else begin : g_sn
        logic [WIDTH:0] f_q;
        always_ff @(posedge clk) begin
            if (reset)      f_q <= '0;
            else if (en[0]) f_q <= f_c;
        end
        assign lzc_in = f_q;
        if (STAGES == 3) begin : g_s3
            assign mid_en = en[1];
        end else begin : g_s2
            assign mid_en = 1'b0;
        end
    end

    logic [CW-1:0] cnt_c;
    logic          zero_c;

    lza_lzc_split #(
        .N   (WIDTH + 1),
        .CW  (CW),
        .Reg (STAGES == 3)
    ) u_lzc (
        .clk_i  (clk),
        .rst_i  (reset),
        .en_i   (mid_en),
        .f_i    (lzc_in),
        .cnt_o  (cnt_c),
        .zero_o (zero_c)
    );

    logic [CW-1:0] scnt_q;
    logic          zero_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scnt_q <= '0;
            zero_q <= 1'b0;
        end else if (en[STAGES-1]) begin
            scnt_q <= cnt_c;
            zero_q <= zero_c;
        end
    end

    assign SCnt = scnt_q;
    assign Zero = zero_q;

endmodule

// File: tb/tb_fmalza_pipe.sv
// Directed bench driving STAGES=1,2,3 instances in parallel with shared operands.
module tb_fmalza_pipe;
    localparam int NF   = 4;
    localparam int W    = 16;
    localparam int TAGW = 8;
    localparam int CW   = 5;
    localparam int NV   = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, flush, in_valid, out_ready, cin, sub;
    logic [2:0]        sel;
    logic [W-1:0]      a;
    logic [2*NF+1:0]   pm;
    logic [TAGW-1:0]   tag_in;
    logic [2:0]        in_ready, out_valid, zero;
    logic [CW-1:0]     scnt    [3];
    logic [TAGW-1:0]   tag_out [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fmalza_pipe #(
            .NF     (NF),
            .WIDTH  (W),
            .STAGES (g + 1),
            .TAGW   (TAGW)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .in_valid  (in_valid & sel[g]),
            .in_ready  (in_ready[g]),
            .A         (a),
            .Pm        (pm),
            .Cin       (cin),
            .sub       (sub),
            .tag_in    (tag_in),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .SCnt      (scnt[g]),
            .Zero      (zero[g]),
            .tag_out   (tag_out[g])
        );
    end

    int npass = 0, nfail = 0, ntot = 0;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal per-bit reading of the F equation followed by a top-down zero scan.
    function automatic void model(input logic [W-1:0] aa, input logic [2*NF+1:0] pp,
                                  input logic ci, input logic su,
                                  output int cnt, output logic z);
        logic [W-1:0] b;
        logic [W:0]   f;
        logic         pi1, gi, ki, gm, km;
        b = {5'b0, pp, 1'b0};
        for (int i = 0; i < W; i++) begin
            gi = aa[i] & b[i];
            ki = ~aa[i] & ~b[i];
            if (i == W - 1) pi1 = su;
            else            pi1 = aa[i+1] ^ b[i+1];
            if (i == 0) begin
                gm = ci;
                km = ~ci;
            end else begin
                gm = aa[i-1] & b[i-1];
                km = ~aa[i-1] & ~b[i-1];
            end
            f[i] = (pi1 & ((gi & ~km) | (ki & ~gm))) | (~pi1 & ((ki & ~km) | (gi & ~gm)));
        end
        f[W] = ~su & (aa[W-1] ^ b[W-1]);
        cnt = W + 1;
        for (int i = W; i >= 0; i--) begin
            if (f[i] && cnt == W + 1) cnt = W - i;
        end
        z = (f == '0);
    endfunction

    logic [W-1:0]    va   [NV];
    logic [2*NF+1:0] vpm  [NV];
    logic            vcin [NV];
    logic            vsub [NV];
    int              ecnt [NV];
    logic            ez   [NV];

    task automatic drive(input int i, input logic [TAGW-1:0] t);
        a      = va[i];
        pm     = vpm[i];
        cin    = vcin[i];
        sub    = vsub[i];
        tag_in = t;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Hand-computed directed vectors.
        va[0] = 16'h0000; vpm[0] = 10'h000; vcin[0] = 0; vsub[0] = 0; ecnt[0] = 17; ez[0] = 1;
        va[1] = 16'h8000; vpm[1] = 10'h000; vcin[1] = 0; vsub[1] = 0; ecnt[1] = 0;  ez[1] = 0;
        va[2] = 16'h8000; vpm[2] = 10'h000; vcin[2] = 0; vsub[2] = 1; ecnt[2] = 2;  ez[2] = 0;
        va[3] = 16'h0000; vpm[3] = 10'h200; vcin[3] = 0; vsub[3] = 0; ecnt[3] = 5;  ez[3] = 0;
        for (int i = 4; i < NV; i++) begin
            va[i]   = 16'($urandom);
            vpm[i]  = 10'($urandom);
            vcin[i] = 1'($urandom);
            vsub[i] = 1'($urandom);
            model(va[i], vpm[i], vcin[i], vsub[i], ecnt[i], ez[i]);
        end

        reset = 1; flush = 0; in_valid = 0; out_ready = 1; sel = 3'b111;
        drive(0, 8'h00);
        step();
        step();
        reset = 0;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("s%0d_rst_valid", g + 1), 32'(out_valid[g]), 32'd0);
            check($sformatf("s%0d_rst_scnt", g + 1), 32'(scnt[g]), 32'd0);
            check($sformatf("s%0d_rst_zero", g + 1), 32'(zero[g]), 32'd0);
            check($sformatf("s%0d_rst_tag", g + 1), 32'(tag_out[g]), 32'd0);
        end
        check("rst_in_ready", 32'(in_ready), 32'b111);

        // Streaming: output in cycle c carries the vector presented in cycle c-STAGES.
        for (int c = 0; c < NV + 3; c++) begin
            if (c < NV) begin
                drive(c, 8'(8'h10 + c));
                in_valid = 1;
            end else begin
                in_valid = 0;
            end
            step();
            for (int g = 0; g < 3; g++) begin
                int idx;
                idx = c - g;
                if (idx >= 0 && idx < NV) begin
                    check($sformatf("s%0d_v%0d_valid", g + 1, idx), 32'(out_valid[g]), 32'd1);
                    check($sformatf("s%0d_v%0d_scnt", g + 1, idx), 32'(scnt[g]), 32'(ecnt[idx]));
                    check($sformatf("s%0d_v%0d_zero", g + 1, idx), 32'(zero[g]), 32'(ez[idx]));
                    check($sformatf("s%0d_v%0d_tag", g + 1, idx), 32'(tag_out[g]),
                          32'(8'h10 + idx));
                end else begin
                    check($sformatf("s%0d_c%0d_idle", g + 1, c), 32'(out_valid[g]), 32'd0);
                end
            end
        end

        // Backpressure on the two-stage pipe only.
        sel = 3'b010; out_ready = 0; in_valid = 1;
        drive(3, 8'd1);
        #1 check("bp_rdy1", 32'(in_ready[1]), 32'd1);
        step();
        drive(3, 8'd2);
        #1 check("bp_rdy2", 32'(in_ready[1]), 32'd1);
        step();
        drive(3, 8'd3);
        #1 check("bp_rdy3_blocked", 32'(in_ready[1]), 32'd0);
        for (int s = 0; s < 3; s++) begin
            check("bp_hold_valid", 32'(out_valid[1]), 32'd1);
            check("bp_hold_tag", 32'(tag_out[1]), 32'd1);
            check("bp_hold_scnt", 32'(scnt[1]), 32'd5);
            check("bp_hold_rdy", 32'(in_ready[1]), 32'd0);
            step();
        end
        out_ready = 1;
        #1 check("bp_release_rdy", 32'(in_ready[1]), 32'd1);
        step();
        in_valid = 0;
        check("bp_out2_valid", 32'(out_valid[1]), 32'd1);
        check("bp_out2_tag", 32'(tag_out[1]), 32'd2);
        step();
        check("bp_out3_valid", 32'(out_valid[1]), 32'd1);
        check("bp_out3_tag", 32'(tag_out[1]), 32'd3);
        step();
        check("bp_drained", 32'(out_valid[1]), 32'd0);

        // Flush with entries in flight and an input offered in the flush cycle.
        sel = 3'b111; out_ready = 0; in_valid = 1;
        drive(1, 8'h21);
        step();
        drive(1, 8'h22);
        step();
        drive(1, 8'h23);
        flush = 1;
        step();
        flush = 0; in_valid = 0; out_ready = 1;
        check("flush_in_ready", 32'(in_ready), 32'b111);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("flush_quiet%0d", s), 32'(out_valid), 32'd0);
            step();
        end

        // Reset with entries loaded at the outputs and an input offered.
        out_ready = 0; in_valid = 1;
        drive(0, 8'hAA);
        step();
        in_valid = 0;
        step();
        step();
        check("pre_rst_valid", 32'(out_valid), 32'b111);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("s%0d_pre_rst_scnt", g + 1), 32'(scnt[g]), 32'd17);
            check($sformatf("s%0d_pre_rst_tag", g + 1), 32'(tag_out[g]), 32'hAA);
        end
        reset = 1; in_valid = 1;
        drive(1, 8'h55);
        step();
        reset = 0; in_valid = 0; out_ready = 1;
        for (int g = 0; g < 3; g++) begin
            check($sformatf("s%0d_mid_rst_valid", g + 1), 32'(out_valid[g]), 32'd0);
            check($sformatf("s%0d_mid_rst_scnt", g + 1), 32'(scnt[g]), 32'd0);
            check($sformatf("s%0d_mid_rst_zero", g + 1), 32'(zero[g]), 32'd0);
            check($sformatf("s%0d_mid_rst_tag", g + 1), 32'(tag_out[g]), 32'd0);
        end
        for (int s = 0; s < 4; s++) begin
            step();
            check($sformatf("rst_quiet%0d", s), 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/fmalza_pipe.md
Name: fmalza_pipe

Overview:
Pipelined, parametrised leading zero anticipator for the FMA datapath. Computes the Schmookler–Nowka leading-digit pattern F from the aligned addend, the product, the carry-in and the subtract flag, then produces the normalisation shift count and an all-zero flag. Adds configurable pipeline depth, valid/ready backpressure, flush and a sideband tag, so it can sit between the FMA alignment stage and the post-processing normaliser.

Parameters:
NF, 52, fraction width of the widest format
WIDTH, 3*NF+4, aligned-addend / sum width (160 at default)
STAGES, 2, pipeline depth; legal values 1, 2, 3; elaboration error otherwise
TAGW, 8, sideband tag width
CW, $clog2(WIDTH+2), count width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
flush  in  1  discard all in-flight entries
in_valid  in  1  input operands valid
in_ready  out  1  block can accept this cycle
A  in  WIDTH  aligned addend
Pm  in  2*NF+2  product
Cin  in  1  carry in
sub  in  1  effective subtraction
tag_in  in  TAGW  sideband, travels with operands
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
SCnt  out  CW  normalisation shift count
Zero  out  1  F is all zero
tag_out  out  TAGW  tag of current result

Behaviour:
- Arithmetic, per entry: B = {(NF+1) zeros, Pm, 1'b0}; P=A^B, G=A&B, K=~A&~B; Pp1={sub,P[WIDTH-1:1]}; Gm1={G[WIDTH-2:0],Cin}; Km1={K[WIDTH-2:0],~Cin}.
- F[WIDTH]=~sub&P[WIDTH-1]; F[WIDTH-1:0]=(Pp1&(G&~Km1|K&~Gm1))|(~Pp1&(K&~Km1|G&~Gm1)).
- SCnt = count of leading zeros of F (WIDTH+1 bits), range 0..WIDTH+1. Zero=1 iff F==0, in which case SCnt=WIDTH+1. One-position LZA error is not corrected here.
- Stage split:
  - STAGES=1: everything combinational into a single output register.
  - STAGES=2: register F, then LZC into the output register.
  - STAGES=3: register F; stage 2 registers the upper-half and lower-half counts plus their zero flags (split at floor((WIDTH+1)/2)); stage 3 merges them.
- Handshake: each stage holds valid bit v[k]. Stage k loads when ~v[k] | (downstream takes). Output stage takes when out_ready. in_ready = ~v[1] | stage-1 advance; it is combinational from out_ready through the chain, with no registered bubble.
- Transfer happens on in_valid&in_ready at a rising clk; out_valid=v[STAGES].
- Latency: STAGES cycles from acceptance to out_valid with out_ready=1. Throughput: 1 per cycle. Order is preserved.
- Stall: with out_ready=0 and the pipe full, in_ready=0 and all data and tag registers hold. SCnt, Zero and tag_out are stable while out_valid&~out_ready.
- Data registers load only on advance; valid bits clear when a stage empties without refill.
- flush: next cycle all v[k]=0. An input presented in the flush cycle is dropped. in_ready is 1 in the cycle after flush.
- reset: priority over flush. Next cycle all v[k]=0, SCnt=0, Zero=0, tag_out=0, and all internal data registers are 0. Reset mid-operation drops in-flight entries with no output.
- Simultaneous accept and emit on a full pipe is legal and keeps the pipe full.

Decomposition:
- Shared fpu package: lza_pattern function (the F equation) and the CW width constant, for reuse by the fused add path.
- One sub-module, lza_lzc_split: two-half leading-zero counter plus merge, with an optional register between them selected by parameter. Used for STAGES=3 and combinationally otherwise.

Test Plan:
All scenarios use NF=4, WIDTH=16, STAGES=2, out_ready=1 unless stated.
- A=0, Pm=0, Cin=0, sub=0 -> two cycles later out_valid=1, Zero=1, SCnt=17.
- A=16'h8000, Pm=0, sub=0 -> Zero=0, SCnt=0; same operands with sub=1 -> SCnt != 0 (F[16]=0).
- A=0, Pm=10'h200, Cin=0, sub=0 -> SCnt=5, Zero=0, tag_out equals tag_in.
- Back-to-back stream of 20 random vectors -> one result per cycle after 2-cycle latency; every result matches the golden model; tags arrive in order.
- out_ready=0, offer tags 1, 2, 3 -> in_ready falls after 2 acceptances; outputs stay frozen on tag 1; releasing out_ready delivers 1, 2, 3 with no loss or duplication.
- Two entries in flight, assert flush (with in_valid=1) -> no out_valid for those entries or the flush-cycle input. Repeat with reset -> all outputs 0 next cycle. Rerun the full suite with STAGES=1 and STAGES=3 and confirm latency equals STAGES.
